// File: rtl/op_sequencer.sv
// Stack-machine op sequencer: pops operands, runs ALU/compare, pushes results
// and reports the PC increment / jump for each accepted op.
module op_sequencer #(
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    input  logic [2:0]          op_kind,
    input  logic [3:0]          op_alu,
    input  logic [3:0]          op_cmp,
    input  logic [DATA_W-1:0]   op_const,
    input  logic [7:0]          arg1,
    input  logic [7:0]          arg2,
    input  logic [1:0]          argc,
    input  logic [1:0]          pops,
    input  logic [DATA_W-1:0]   stack_rdata,
    input  logic                stack_done,
    output logic [DATA_W-1:0]   stack_wdata,
    output logic                stack_push,
    output logic                stack_trigger,
    output logic [OFFSET_W-1:0] offset,
    output logic                jump,
    output logic                op_done,
    output logic                err,
    output logic                busy
);
    localparam int SH = $clog2(DATA_W);
    localparam logic [2:0] K_NOP = 3'd0, K_CONST = 3'd1, K_ARG = 3'd2,
                           K_ALU = 3'd3, K_CMP = 3'd4, K_GOTO = 3'd5;

    typedef enum logic [2:0] {IDLE, POP, POPWAIT, COMP, EXEC, PUSHWAIT} state_t;
    state_t state;

    logic [2:0]          k_q;
    logic [3:0]          alu_q, cmp_q;
    logic [DATA_W-1:0]   const_q, opa, opb;
    logic [7:0]          arg1_q, arg2_q;
    logic [1:0]          argc_q, rem;
    logic                taken;

    logic                illegal, cmp_res;
    logic [DATA_W-1:0]   alu_res, push_data, rhs;
    logic [SH-1:0]       shamt;
    logic [OFFSET_W-1:0] done_off, nop_off;

    always_comb begin
        illegal = (op_kind > K_GOTO) || (pops == 2'd3) ||
                  (op_kind == K_ALU && op_alu > 4'd9) ||
                  (op_kind == K_CMP && op_cmp[2:0] > 3'd5) ||
                  (op_kind == K_ARG && !(argc == 2'd1 || argc == 2'd2));
        shamt = opb[SH-1:0];
        alu_res = '0;
        case (alu_q)
            4'd0: alu_res = opa + opb;
            4'd1: alu_res = opa - opb;
            4'd2: alu_res = opa * opb;
            4'd3: alu_res = opa & opb;
            4'd4: alu_res = opa | opb;
            4'd5: alu_res = opa ^ opb;
            4'd6: alu_res = opa << shamt;
            4'd7: alu_res = DATA_W'($signed(opa) >>> shamt);
            4'd8: alu_res = opa >> shamt;
            4'd9: alu_res = '0 - opa;
            default: alu_res = '0;
        endcase
        rhs = cmp_q[3] ? opb : '0;
        cmp_res = 1'b0;
        case (cmp_q[2:0])
            3'd0: cmp_res = (opa == rhs);
            3'd1: cmp_res = (opa != rhs);
            3'd2: cmp_res = ($signed(opa) <  $signed(rhs));
            3'd3: cmp_res = ($signed(opa) <= $signed(rhs));
            3'd4: cmp_res = ($signed(opa) >= $signed(rhs));
            3'd5: cmp_res = ($signed(opa) >  $signed(rhs));
            default: cmp_res = 1'b0;
        endcase
        push_data = alu_res;
        if (k_q == K_CONST)
            push_data = const_q;
        else if (k_q == K_ARG && argc_q == 2'd1)
            push_data = DATA_W'($signed(arg1_q));
        else if (k_q == K_ARG)
            push_data = DATA_W'($signed({arg1_q, arg2_q}));
        done_off = taken ? OFFSET_W'($signed({arg1_q, arg2_q}))
                         : OFFSET_W'({1'b0, argc_q} + 3'd1);
        nop_off  = OFFSET_W'({1'b0, argc} + 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stack_trigger <= 1'b0;
            stack_push    <= 1'b0;
            stack_wdata   <= '0;
            op_done       <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            jump          <= 1'b0;
            offset        <= OFFSET_W'(1);
            opa           <= '0;
            opb           <= '0;
            k_q           <= K_NOP;
            alu_q         <= '0;
            cmp_q         <= '0;
            const_q       <= '0;
            arg1_q        <= '0;
            arg2_q        <= '0;
            argc_q        <= '0;
            rem           <= '0;
            taken         <= 1'b0;
        end else begin
            stack_trigger <= 1'b0;
            op_done       <= 1'b0;
            err           <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // op_done high here means the previous op finishes this cycle
                    if (op_valid && !op_done) begin
                        if (op_kind == K_NOP) begin
                            op_done <= 1'b1;
                            offset  <= nop_off;
                            jump    <= 1'b0;
                        end else begin
                            busy    <= 1'b1;
                            k_q     <= op_kind;
                            alu_q   <= op_alu;
                            cmp_q   <= op_cmp;
                            const_q <= op_const;
                            arg1_q  <= arg1;
                            arg2_q  <= arg2;
                            argc_q  <= argc;
                            rem     <= pops;
                            opa     <= '0;
                            opb     <= '0;
                            taken   <= (op_kind == K_GOTO);
                            if (illegal) begin
                                op_done <= 1'b1;
                                err     <= 1'b1;
                            end else if ((op_kind == K_ALU || op_kind == K_CMP) && pops != 2'd0)
                                state <= POP;
                            else if (op_kind == K_CMP)
                                state <= COMP;
                            else
                                state <= EXEC;
                        end
                    end
                end
                POP: begin
                    stack_trigger <= 1'b1;
                    stack_push    <= 1'b0;
                    state         <= POPWAIT;
                end
                POPWAIT: if (stack_done) begin
                    // with two pops the top of stack is the right-hand operand
                    if (rem == 2'd2) opb <= stack_rdata;
                    else             opa <= stack_rdata;
                    rem <= rem - 2'd1;
                    if (rem != 2'd1)       state <= POP;
                    else if (k_q == K_CMP) state <= COMP;
                    else                   state <= EXEC;
                end
                COMP: begin
                    taken <= cmp_res;
                    state <= EXEC;
                end
                EXEC: begin
                    if (k_q == K_CMP || k_q == K_GOTO) begin
                        op_done <= 1'b1;
                        offset  <= done_off;
                        jump    <= taken;
                        state   <= IDLE;
                    end else begin
                        stack_trigger <= 1'b1;
                        stack_push    <= 1'b1;
                        stack_wdata   <= push_data;
                        state         <= PUSHWAIT;
                    end
                end
                PUSHWAIT: if (stack_done) begin
                    op_done <= 1'b1;
                    offset  <= done_off;
                    jump    <= taken;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed spec scenarios plus random ops checked
// against an arithmetic reference model; the bench plays the stack.
module tb_op_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        op_valid, stack_done, stack_push, stack_trigger, jump, op_done, err, busy;
    logic [2:0]  op_kind;
    logic [3:0]  op_alu, op_cmp;
    logic [31:0] op_const, stack_rdata, stack_wdata;
    logic [7:0]  arg1, arg2;
    logic [1:0]  argc, pops;
    logic [15:0] offset;

    int total = 0, bad = 0;
    int r_trig, r_push, r_lat;
    logic [31:0] r_wd;
    logic [15:0] r_off;
    bit r_done, r_err, r_jmp, r_busy;

    always #5 clk = ~clk;

    op_sequencer #(.DATA_W(32), .OFFSET_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_kind(op_kind), .op_alu(op_alu),
        .op_cmp(op_cmp), .op_const(op_const), .arg1(arg1), .arg2(arg2), .argc(argc),
        .pops(pops), .stack_rdata(stack_rdata), .stack_done(stack_done),
        .stack_wdata(stack_wdata), .stack_push(stack_push), .stack_trigger(stack_trigger),
        .offset(offset), .jump(jump), .op_done(op_done), .err(err), .busy(busy));

    // Reference: what one op should do, given the words the stack hands back in pop order.
    function automatic void model(input logic [2:0] k, input logic [3:0] alu, cmp,
                                  input logic [31:0] cn, input logic [7:0] a1, a2,
                                  input logic [1:0] ac, ps, input logic [31:0] w0, w1,
                                  output bit e_err, output int e_pops, output bit e_push,
                                  output logic [31:0] e_wd, output bit e_jmp, output logic [15:0] e_off);
        int a, b, rhs, sh;
        bit tk;
        e_err = (k > 5) || (k != 0 && ps == 3) || (k == 3 && alu > 9) ||
                (k == 4 && cmp[2:0] > 5) || (k == 2 && ac != 1 && ac != 2);
        e_pops = (!e_err && (k == 3 || k == 4)) ? int'(ps) : 0;
        e_push = !e_err && (k == 1 || k == 2 || k == 3);
        a = (e_pops == 2) ? int'(w1) : (e_pops == 1) ? int'(w0) : 0;
        b = (e_pops == 2) ? int'(w0) : 0;
        sh = b & 31;
        e_wd = 0;
        if (k == 1) e_wd = cn;
        else if (k == 2) e_wd = (ac == 1) ? 32'(int'($signed(a1))) : 32'(int'($signed({a1, a2})));
        else if (k == 3)
            case (alu)
                0: e_wd = a + b;
                1: e_wd = a - b;
                2: e_wd = 32'(longint'(unsigned'(a)) * longint'(unsigned'(b)));
                3: e_wd = a & b;
                4: e_wd = a | b;
                5: e_wd = a ^ b;
                6: e_wd = unsigned'(a) << sh;
                7: e_wd = a >>> sh;
                8: e_wd = unsigned'(a) >> sh;
                default: e_wd = -a;
            endcase
        rhs = cmp[3] ? b : 0;
        tk = (k == 5);
        if (k == 4)
            case (cmp[2:0])
                0: tk = (a == rhs);
                1: tk = (a != rhs);
                2: tk = (a < rhs);
                3: tk = (a <= rhs);
                4: tk = (a >= rhs);
                default: tk = (a > rhs);
            endcase
        e_jmp = tk;
        e_off = tk ? {a1, a2} : 16'(ac) + 16'd1;
    endfunction

    // Issue one op, act as the stack (random latency, stray dones while idle), record results.
    task automatic run_op(input logic [2:0] k, input logic [3:0] alu, cmp, input logic [31:0] cn,
                          input logic [7:0] a1, a2, input logic [1:0] ac, ps, input logic [31:0] w0, w1);
        int pend = -1, pidx = 0;
        r_trig = 0; r_push = 0; r_wd = 0; r_off = 0; r_lat = 0;
        r_done = 0; r_err = 0; r_jmp = 0; r_busy = 0;
        @(negedge clk);
        op_valid = 1; op_kind = k; op_alu = alu; op_cmp = cmp; op_const = cn;
        arg1 = a1; arg2 = a2; argc = ac; pops = ps;
        for (int c = 0; c < 200 && !r_done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                op_valid = 0; op_kind = 3'($urandom); op_alu = 4'($urandom); op_cmp = 4'($urandom);
                op_const = $urandom; arg1 = 8'($urandom); arg2 = 8'($urandom);
                argc = 2'($urandom); pops = 2'($urandom);
            end
            stack_done = 0;
            if (op_done) begin
                r_done = 1; r_err = err; r_jmp = jump; r_off = offset; r_busy = busy; r_lat = c + 1;
            end
            if (stack_trigger) begin
                r_trig++;
                if (stack_push) begin r_push++; r_wd = stack_wdata; end
                pend = $urandom_range(0, 2);
            end
            if (pend == 0) begin
                stack_done = 1; stack_rdata = (pidx == 0) ? w0 : w1; pidx++; pend = -1;
            end else if (pend > 0) pend--;
            else if (!r_done && $urandom_range(0, 3) == 0) begin
                stack_done = 1; stack_rdata = $urandom;
            end
        end
        stack_done = 0;
    endtask

    task automatic test_reset();
        op_valid = 0; op_kind = 0; op_alu = 0; op_cmp = 0; op_const = 0; arg1 = 0; arg2 = 0;
        argc = 0; pops = 0; stack_rdata = 0; stack_done = 0;
        rst_n = 0;
        #12;
        total++;
        if ({stack_trigger, stack_push, op_done, err, busy, jump} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {stack_trigger, stack_push, op_done, err, busy, jump});
        end
        total++;
        if (stack_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", stack_wdata); end
        total++;
        if (offset !== 16'd1) begin bad++; $display("FAIL reset_offset got=%h want=1", offset); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_const();
        run_op(3'd1, 4'd0, 4'd0, 32'h5, 8'h0, 8'h0, 2'd0, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || r_trig != 1 || r_push != 1 || r_err) begin
            bad++; $display("FAIL const_ctrl got done=%0b trig=%0d push=%0d want 1 1 1", r_done, r_trig, r_push);
        end
        total++;
        if (r_wd !== 32'h5 || r_off !== 16'd1 || r_jmp !== 1'b0) begin
            bad++; $display("FAIL const_data got wd=%h off=%h jmp=%0b want 5 1 0", r_wd, r_off, r_jmp);
        end
    endtask

    task automatic test_argpush();
        run_op(3'd2, 4'd0, 4'd0, 32'h0, 8'hFF, 8'h80, 2'd2, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || r_trig != 1 || r_wd !== 32'hFFFF_FF80 || r_off !== 16'd3) begin
            bad++; $display("FAIL argpush got trig=%0d wd=%h off=%h want 1 ffffff80 3", r_trig, r_wd, r_off);
        end
        run_op(3'd2, 4'd0, 4'd0, 32'h0, 8'h80, 8'h11, 2'd1, 2'd0, 32'h0, 32'h0);
        total++;
        if (r_wd !== 32'hFFFF_FF80 || r_off !== 16'd2) begin
            bad++; $display("FAIL argpush1 got wd=%h off=%h want ffffff80 2", r_wd, r_off);
        end
    endtask

    task automatic test_alu();
        run_op(3'd3, 4'd1, 4'd0, 32'h0, 8'h0, 8'h0, 2'd0, 2'd2, 32'd3, 32'd10);
        total++;
        if (!r_done || r_trig != 3 || r_push != 1 || r_wd !== 32'd7) begin
            bad++; $display("FAIL alu_sub got trig=%0d push=%0d wd=%h want 3 1 7", r_trig, r_push, r_wd);
        end
        run_op(3'd3, 4'd2, 4'd0, 32'h0, 8'h0, 8'h0, 2'd0, 2'd2, 32'h10000, 32'h10000);
        total++;
        if (!r_done || r_trig != 3 || r_wd !== 32'h0) begin
            bad++; $display("FAIL alu_mul got trig=%0d wd=%h want 3 0", r_trig, r_wd);
        end
    endtask

    task automatic test_cmp();
        run_op(3'd4, 4'd0, 4'h2, 32'h0, 8'hFF, 8'hFA, 2'd2, 2'd1, 32'hFFFF_FFFF, 32'h0);
        total++;
        if (!r_done || r_trig != 1 || r_jmp !== 1'b1 || r_off !== 16'hFFFA) begin
            bad++; $display("FAIL cmp_taken got trig=%0d jmp=%0b off=%h want 1 1 fffa", r_trig, r_jmp, r_off);
        end
        run_op(3'd4, 4'd0, 4'h2, 32'h0, 8'hFF, 8'hFA, 2'd2, 2'd1, 32'h1, 32'h0);
        total++;
        if (!r_done || r_jmp !== 1'b0 || r_off !== 16'd3) begin
            bad++; $display("FAIL cmp_not got jmp=%0b off=%h want 0 3", r_jmp, r_off);
        end
    endtask

    task automatic test_goto_nop();
        run_op(3'd5, 4'd0, 4'd0, 32'h0, 8'h00, 8'h10, 2'd2, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || r_lat > 3 || r_trig != 0 || r_off !== 16'h0010 || r_jmp !== 1'b1) begin
            bad++; $display("FAIL goto got lat=%0d trig=%0d off=%h jmp=%0b want <=3 0 0010 1", r_lat, r_trig, r_off, r_jmp);
        end
        run_op(3'd0, 4'd0, 4'd0, 32'h0, 8'h0, 8'h0, 2'd3, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || r_lat != 1 || r_trig != 0 || r_off !== 16'd4 || r_busy || r_err) begin
            bad++; $display("FAIL nop got lat=%0d trig=%0d off=%h busy=%0b want 1 0 4 0", r_lat, r_trig, r_off, r_busy);
        end
    endtask

    task automatic test_illegal();
        run_op(3'd3, 4'd0, 4'd0, 32'h0, 8'h0, 8'h0, 2'd0, 2'd3, 32'h1, 32'h2);
        total++;
        if (!r_done || !r_err || r_trig != 0) begin
            bad++; $display("FAIL illegal_pops got done=%0b err=%0b trig=%0d want 1 1 0", r_done, r_err, r_trig);
        end
        run_op(3'd7, 4'd0, 4'd0, 32'h0, 8'h0, 8'h0, 2'd0, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || !r_err || r_trig != 0) begin
            bad++; $display("FAIL illegal_kind got done=%0b err=%0b trig=%0d want 1 1 0", r_done, r_err, r_trig);
        end
    endtask

    task automatic test_random();
        logic [2:0] k; logic [3:0] alu, cmp; logic [31:0] cn, w0, w1, e_wd;
        logic [7:0] a1, a2; logic [1:0] ac, ps; logic [15:0] e_off;
        bit e_err, e_push, e_jmp; int e_pops;
        for (int i = 0; i < 80; i++) begin
            k   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            alu = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cmp = {1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5))};
            ps  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ac  = 2'($urandom_range(0, 3));
            cn  = $urandom; a1 = 8'($urandom); a2 = 8'($urandom);
            w0  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            w1  = ($urandom_range(0, 2) == 0) ? w0 : $urandom;
            model(k, alu, cmp, cn, a1, a2, ac, ps, w0, w1, e_err, e_pops, e_push, e_wd, e_jmp, e_off);
            run_op(k, alu, cmp, cn, a1, a2, ac, ps, w0, w1);
            total++;
            if (!r_done || r_err != e_err || r_trig != e_pops + int'(e_push) || r_busy != (k != 0)) begin
                bad++;
                $display("FAIL rand%0d_ctrl k=%0d got done=%0b err=%0b trig=%0d busy=%0b want 1 %0b %0d %0b",
                         i, k, r_done, r_err, r_trig, r_busy, e_err, e_pops + int'(e_push), k != 0);
            end
            if (!e_err) begin
                total++;
                if (r_off !== e_off || r_jmp != e_jmp) begin
                    bad++; $display("FAIL rand%0d_pc k=%0d got off=%h jmp=%0b want %h %0b", i, k, r_off, r_jmp, e_off, e_jmp);
                end
            end
            if (e_push) begin
                total++;
                if (r_wd !== e_wd) begin
                    bad++; $display("FAIL rand%0d_wdata k=%0d alu=%0d got=%h want=%h", i, k, alu, r_wd, e_wd);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        int c = 0;
        bit seen = 0;
        @(negedge clk);
        op_valid = 1; op_kind = 3'd3; op_alu = 4'd0; pops = 2'd2; argc = 2'd0;
        @(negedge clk); op_valid = 0;
        while (!stack_trigger && c < 20) begin @(negedge clk); c++; end
        total++;
        if (!stack_trigger) begin bad++; $display("FAIL midop_trigger got=0 want=1"); end
        @(negedge clk);
        rst_n = 0;
        #2;
        total++;
        if ({stack_trigger, stack_push, op_done, err, busy, jump} !== 6'b0 || offset !== 16'd1 || stack_wdata !== 32'h0) begin
            bad++; $display("FAIL midop_reset got ctrl=%b off=%h wd=%h want 000000 1 0",
                            {stack_trigger, stack_push, op_done, err, busy, jump}, offset, stack_wdata);
        end
        @(negedge clk);
        rst_n = 1; stack_done = 1; stack_rdata = 32'hDEAD;
        @(negedge clk); stack_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (op_done || stack_trigger || busy) seen = 1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midop_late_done got activity=1 want=0"); end
        run_op(3'd1, 4'd0, 4'd0, 32'h1234_5678, 8'h0, 8'h0, 2'd1, 2'd0, 32'h0, 32'h0);
        total++;
        if (!r_done || r_trig != 1 || r_wd !== 32'h1234_5678 || r_off !== 16'd2) begin
            bad++; $display("FAIL midop_next got done=%0b trig=%0d wd=%h off=%h want 1 1 12345678 2", r_done, r_trig, r_wd, r_off);
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_argpush();
        test_alu();
        test_cmp();
        test_goto_nop();
        test_illegal();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
